// File: rtl/ula_wb_pkg.sv
// ---------------------------------------------------------------------------
// ula_wb_pkg
// Shared types and constants for the BIP-2 execute-stage writeback unit.
//   DEFAULT_DATA_W : datapath width, must match the ALU operand/result width
//   op_e           : command opcode (NOP / ALU / LOAD / STORE)
//   cond_e         : branch condition code (JMP ... NEVER)
//   state_e        : writeback controller states
// ---------------------------------------------------------------------------
package ula_wb_pkg;

   localparam int DEFAULT_DATA_W = 11;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_ALU   = 2'd1,
      OP_LOAD  = 2'd2,
      OP_STORE = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      COND_JMP   = 3'd0,
      COND_BEQ   = 3'd1,
      COND_BNE   = 3'd2,
      COND_BGT   = 3'd3,
      COND_BGE   = 3'd4,
      COND_BLT   = 3'd5,
      COND_BLE   = 3'd6,
      COND_NEVER = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ula_writeback_branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch-condition evaluator against STATUS.
//   cond  in  3 : condition code (cond_e encoding)
//   z     in  1 : STATUS zero flag
//   n     in  1 : STATUS negative flag
//   taken out 1 : branch is taken
// ---------------------------------------------------------------------------
module branch_cond_eval
   import ula_wb_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       z,
   input  logic       n,
   output logic       taken
);

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      taken = 1'b0;
      case (cond_e'(cond))
         COND_JMP:   taken = 1'b1;
         COND_BEQ:   taken = z;
         COND_BNE:   taken = !z;
         COND_BGT:   taken = !z && !n;
         COND_BGE:   taken = !n;
         COND_BLT:   taken = n;
         COND_BLE:   taken = z || n;
         COND_NEVER: taken = 1'b0;
         default:    taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ula_writeback.sv
// ---------------------------------------------------------------------------
// ula_writeback
// Execute-stage writeback/status unit downstream of the BIP-2 ALU. Captures
// one command per valid/ready handshake, commits the accumulator and STATUS,
// evaluates branches, drives a store handshake and pulses done_o.
//
// Build option: define ULA_WB_LOAD_FLAGS_EN to make LOAD also update Z/N
// from the loaded value; undefined, LOAD leaves STATUS unchanged.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   : command handshake (ready only in IDLE)
//   cmd_op_i, cmd_cond_i  : opcode (op_e), branch condition (cond_e)
//   cmd_br_i              : command is a branch (opcode ignored)
//   ula_result_i/z_i/n_i  : ALU result and flags, sampled at accept
//   ld_data_i             : LOAD data, sampled at accept
//   acc_o, z_o, n_o       : accumulator and STATUS
//   br_taken_o            : taken pulse, coincident with done_o
//   st_valid_o/data_o     : store request toward memory, st_ready_i accepts
//   done_o                : one-cycle completion pulse
// ---------------------------------------------------------------------------
module ula_writeback
   import ula_wb_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [2:0]        cmd_cond_i,
   input  logic              cmd_br_i,
   input  logic [DATA_W-1:0] ula_result_i,
   input  logic              ula_z_i,
   input  logic              ula_n_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic [DATA_W-1:0] acc_o,
   output logic              z_o,
   output logic              n_o,
   output logic              br_taken_o,
   output logic              st_valid_o,
   output logic [DATA_W-1:0] st_data_o,
   input  logic              st_ready_i,
   output logic              done_o
);

`ifdef ULA_WB_LOAD_FLAGS_EN
   localparam bit LOAD_FLAGS_EN = 1'b1;
`else
   localparam bit LOAD_FLAGS_EN = 1'b0;
`endif

   state_e            state_q, state_d;

   // Command captured at accept; inputs are ignored for the rest of the op.
   op_e               op_q;
   logic [2:0]        cond_q;
   logic              br_q;
   logic [DATA_W-1:0] res_q;
   logic              uz_q;
   logic              un_q;
   logic [DATA_W-1:0] ld_q;

   logic [DATA_W-1:0] acc_q;
   logic              z_q;
   logic              n_q;
   logic              taken_q;
   logic              taken_w;

   logic              accept;

   assign accept = (state_q == ST_IDLE) && cmd_valid_i;

   // Branches read STATUS as committed by earlier commands; commands never
   // overlap, so the live z_q/n_q are always the right operands.
   branch_cond_eval u_cond (
      .cond  (cond_q),
      .z     (z_q),
      .n     (n_q),
      .taken (taken_w)
   );

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_valid_i) state_d = ST_EXEC;
         ST_EXEC:  state_d = (!br_q && op_q == OP_STORE) ? ST_STORE : ST_DONE;
         ST_STORE: if (st_ready_i) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      cmd_ready_o = 1'b0;
      st_valid_o  = 1'b0;
      done_o      = 1'b0;
      br_taken_o  = 1'b0;
      case (state_q)
         ST_IDLE:  cmd_ready_o = 1'b1;
         ST_STORE: st_valid_o  = 1'b1;
         ST_DONE: begin
            done_o     = 1'b1;
            br_taken_o = br_q && taken_q;
         end
         default: ;
      endcase
   end

   // ---------------- command capture ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_NOP;
         cond_q <= '0;
         br_q   <= 1'b0;
         res_q  <= '0;
         uz_q   <= 1'b0;
         un_q   <= 1'b0;
         ld_q   <= '0;
      end else if (accept) begin
         op_q   <= op_e'(cmd_op_i);
         cond_q <= cmd_cond_i;
         br_q   <= cmd_br_i;
         res_q  <= ula_result_i;
         uz_q   <= ula_z_i;
         un_q   <= ula_n_i;
         ld_q   <= ld_data_i;
      end
   end

   // ---------------- commit (closing edge of EXEC) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         taken_q <= 1'b0;
      end else if (state_q == ST_EXEC) begin
         if (br_q) begin
            taken_q <= taken_w;
         end else begin
            case (op_q)
               OP_ALU: begin
                  acc_q <= res_q;
                  z_q   <= uz_q;
                  n_q   <= un_q;
               end
               OP_LOAD: begin
                  acc_q <= ld_q;
                  if (LOAD_FLAGS_EN) begin
                     z_q <= (ld_q == '0);
                     n_q <= ld_q[DATA_W-1];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign acc_o     = acc_q;
   assign z_o       = z_q;
   assign n_o       = n_q;
   // Store data is the accumulator itself, so it is stable for the whole
   // STORE state (nothing commits while waiting for st_ready_i).
   assign st_data_o = acc_q;

endmodule
